regfile_bist: RTL



---
 rtl/regfile_bist_pkg.sv | 35 +++
 rtl/regfile_bist_pattern.sv | 30 +++
 rtl/regfile_bist.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_bist_pkg.sv
// ---------------------------------------------------------------------------
// regfile_bist_pkg
//   Shared definitions for the register-file BIST initiator: sequencer state
//   encoding, register-file geometry and the constant test pattern words.
// ---------------------------------------------------------------------------
package regfile_bist_pkg;

  localparam int NUM_REGS     = 32;
  localparam int ADDR_W       = 5;
  localparam int DATA_W       = 32;
  localparam int NUM_PATTERNS = 5;
  localparam int PAT_W        = 3;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [PAT_W-1:0]  pat_t;
  typedef logic [DATA_W-1:0] word_t;

  // Constant data patterns; the fifth pattern (index 4) is the address itself.
  localparam word_t PAT_ZEROS = 32'h0000_0000;
  localparam word_t PAT_ONES  = 32'hFFFF_FFFF;
  localparam word_t PAT_AA    = 32'hAAAA_AAAA;
  localparam word_t PAT_55    = 32'h5555_5555;

  localparam pat_t  PAT_ADDR_IDX = 3'd4;
  localparam pat_t  LAST_PAT     = pat_t'(NUM_PATTERNS - 1);
  localparam addr_t LAST_ADDR    = addr_t'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/regfile_bist_pattern.sv
// ---------------------------------------------------------------------------
// regfile_bist_pattern
//   Purely combinational pattern generator: maps (pattern index, register
//   address) to the 32-bit word written to / expected from that register.
//
//   pat_i   in   PAT_W   pattern index 0..4
//   addr_i  in   ADDR_W  register address
//   word_o  out  DATA_W  pattern word
// ---------------------------------------------------------------------------
module regfile_bist_pattern
  import regfile_bist_pkg::*;
(
  input  logic [PAT_W-1:0]  pat_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DATA_W-1:0] word_o
);

  always_comb begin
    word_o = PAT_ZEROS;
    case (pat_i)
      3'd0:         word_o = PAT_ZEROS;
      3'd1:         word_o = PAT_ONES;
      3'd2:         word_o = PAT_AA;
      3'd3:         word_o = PAT_55;
      PAT_ADDR_IDX: word_o = {{(DATA_W-ADDR_W){1'b0}}, addr_i};
      default:      word_o = PAT_ZEROS;
    endcase
  end

endmodule

// File: rtl/regfile_bist.sv
// ---------------------------------------------------------------------------
// regfile_bist
//   Built-in self-test initiator for a 32x32 register file with one write port
//   and two asynchronous read ports. For each of five patterns it writes all
//   registers, then reads them back two at a time (port1 walks up, port2 walks
//   down) and compares in the same cycle.
//
//   Clk            in   1           clock, rising edge
//   Reset          in   1           synchronous active-high reset
//   Start          in   1           start a run (honoured in IDLE/DONE only)
//   ReadData1/2    in   32          regfile read data
//   WriteData      out  32          regfile write data
//   WriteRegister  out  5           regfile write address
//   RegWrite       out  1           regfile write enable
//   ReadRegister1/2 out 5           regfile read addresses
//   Busy           out  1           run in progress
//   Done           out  1           run finished, held until Start/Reset
//   Pass           out  1           Done with zero mismatches
//   FailCount      out  FAIL_CNT_W  saturating mismatch count
//   FirstFailAddr  out  5           register address of first mismatch
//   FirstFailPort  out  1           port of first mismatch (0=port1, 1=port2)
// ---------------------------------------------------------------------------
module regfile_bist
  import regfile_bist_pkg::*;
#(
  parameter int FAIL_CNT_W = 8,
  parameter bit CHECK_R0   = 1'b1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [DATA_W-1:0]     ReadData1,
  input  logic [DATA_W-1:0]     ReadData2,
  output logic [DATA_W-1:0]     WriteData,
  output logic [ADDR_W-1:0]     WriteRegister,
  output logic                  RegWrite,
  output logic [ADDR_W-1:0]     ReadRegister1,
  output logic [ADDR_W-1:0]     ReadRegister2,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Pass,
  output logic [FAIL_CNT_W-1:0] FailCount,
  output logic [ADDR_W-1:0]     FirstFailAddr,
  output logic                  FirstFailPort
);

  localparam int SUM_W = FAIL_CNT_W + 2;
  localparam logic [FAIL_CNT_W-1:0] CNT_MAX = '1;

  state_e                state_q;
  addr_t                 addr_q;
  pat_t                  pat_q;
  logic [FAIL_CNT_W-1:0] fail_cnt_q;
  logic [FAIL_CNT_W-1:0] fail_cnt_d;
  addr_t                 first_addr_q;
  logic                  first_port_q;
  logic                  first_seen_q;

  // Port2 walks the address space downwards; 5-bit subtraction never wraps.
  addr_t addr2;
  assign addr2 = LAST_ADDR - addr_q;

  word_t wr_word;
  word_t exp1_raw;
  word_t exp2_raw;

  regfile_bist_pattern u_pat_wr (
    .pat_i  (pat_q),
    .addr_i (addr_q),
    .word_o (wr_word)
  );

  regfile_bist_pattern u_pat_exp1 (
    .pat_i  (pat_q),
    .addr_i (addr_q),
    .word_o (exp1_raw)
  );

  regfile_bist_pattern u_pat_exp2 (
    .pat_i  (pat_q),
    .addr_i (addr2),
    .word_o (exp2_raw)
  );

  // Register 0 handling: either it must read as zero, or it is not compared.
  logic  is_read;
  logic  r0_port1;
  logic  r0_port2;
  logic  cmp_en1;
  logic  cmp_en2;
  word_t exp1;
  word_t exp2;
  logic  mis1;
  logic  mis2;

  assign is_read  = (state_q == ST_READ);
  assign r0_port1 = (addr_q == '0);
  assign r0_port2 = (addr2 == '0);
  assign exp1     = (CHECK_R0 && r0_port1) ? PAT_ZEROS : exp1_raw;
  assign exp2     = (CHECK_R0 && r0_port2) ? PAT_ZEROS : exp2_raw;
  assign cmp_en1  = is_read && (CHECK_R0 || !r0_port1);
  assign cmp_en2  = is_read && (CHECK_R0 || !r0_port2);
  assign mis1     = cmp_en1 && (ReadData1 != exp1);
  assign mis2     = cmp_en2 && (ReadData2 != exp2);

  // Saturating accumulate of 0..2 mismatches per read cycle. The sum is two
  // bits wider than the counter so any carry out means "clamp to all-ones".
  logic [SUM_W-1:0] fail_sum;
  always_comb begin
    fail_sum = {2'b00, fail_cnt_q}
             + {{(SUM_W-1){1'b0}}, mis1}
             + {{(SUM_W-1){1'b0}}, mis2};
    if (|fail_sum[SUM_W-1:FAIL_CNT_W]) begin
      fail_cnt_d = CNT_MAX;
    end else begin
      fail_cnt_d = fail_sum[FAIL_CNT_W-1:0];
    end
  end

  // Sequencer. Address advances every busy cycle; the 31 -> 0 wrap happens
  // only together with a phase change.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      pat_q        <= '0;
      fail_cnt_q   <= '0;
      first_addr_q <= '0;
      first_port_q <= 1'b0;
      first_seen_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (Start) begin
            state_q      <= ST_WRITE;
            addr_q       <= '0;
            pat_q        <= '0;
            fail_cnt_q   <= '0;
            first_addr_q <= '0;
            first_port_q <= 1'b0;
            first_seen_q <= 1'b0;
          end
        end

        ST_WRITE: begin
          if (addr_q == LAST_ADDR) begin
            state_q <= ST_READ;
            addr_q  <= '0;
          end else begin
            addr_q  <= addr_q + addr_t'(1);
          end
        end

        ST_READ: begin
          fail_cnt_q <= fail_cnt_d;
          // Port1 wins when both ports miss in the same cycle.
          if (!first_seen_q && (mis1 || mis2)) begin
            first_seen_q <= 1'b1;
            first_addr_q <= mis1 ? addr_q : addr2;
            first_port_q <= !mis1;
          end
          if (addr_q == LAST_ADDR) begin
            addr_q <= '0;
            if (pat_q < LAST_PAT) begin
              state_q <= ST_WRITE;
              pat_q   <= pat_q + pat_t'(1);
            end else begin
              state_q <= ST_DONE;
            end
          end else begin
            addr_q <= addr_q + addr_t'(1);
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Port drive is decoded straight from the registered state, so a write
  // that is in flight still lands on the edge that samples Reset.
  assign RegWrite      = (state_q == ST_WRITE);
  assign WriteRegister = RegWrite ? addr_q  : '0;
  assign WriteData     = RegWrite ? wr_word : '0;
  assign ReadRegister1 = is_read  ? addr_q  : '0;
  assign ReadRegister2 = is_read  ? addr2   : '0;

  assign Busy          = (state_q == ST_WRITE) || (state_q == ST_READ);
  assign Done          = (state_q == ST_DONE);
  assign Pass          = Done && (fail_cnt_q == '0);
  assign FailCount     = fail_cnt_q;
  assign FirstFailAddr = first_addr_q;
  assign FirstFailPort = first_port_q;

endmodule
